simple_if_rr_arbiter: RTL and testbench

//  Shares one single-port simple memory interface (we/re + addr/data/strb, 2-bit resp) among
//  NUM_REQ requesters, e.g. the AXI-side bridge port and the UART-side engine.

---
 rtl/simple_if_rr_arbiter_if.sv | 41 ++++
 rtl/simple_if_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_simple_if_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_if_rr_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the round-robin arbiter.
// Signal suffixes are from the arbiter's point of view; "slave" is the arbiter, "master" its environment.
interface simple_if_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_we_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ*STRB_W-1:0] req_wstrb_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [NUM_REQ-1:0]        rsp_ready_i;
  logic [DATA_W-1:0]         rsp_rdata_o;
  logic [1:0]                rsp_resp_o;
  logic                      mem_we_o;
  logic                      mem_re_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic [STRB_W-1:0]         mem_wstrb_o;
  logic [DATA_W-1:0]         mem_rdata_i;
  logic [1:0]                mem_resp_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
           rsp_ready_i, mem_rdata_i, mem_resp_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_resp_o,
           mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
           rsp_ready_i, mem_rdata_i, mem_resp_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_resp_o,
           mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/simple_if_rr_arbiter.sv
// Round-robin arbiter sharing one simple memory port among NUM_REQ requesters,
// one transaction in flight, all memory-side outputs registered.
module simple_if_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
) (
  input logic                  clk_i,
  input logic                  arst_ni,
  simple_if_rr_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               we_q, we_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_resp_q, rsp_resp_d;

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; first valid requester wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_found && bus.req_valid_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_oh    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        gnt_oh[i] = gnt_found;
        sel_we    = bus.req_we_i[i];
        sel_addr  = bus.req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata_i[i*DATA_W +: DATA_W];
        sel_wstrb = bus.req_wstrb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  assign bus.req_ready_o = (state_q == IDLE) ? gnt_oh : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          owner_d     = gnt_idx;
          we_d        = sel_we;
          mem_we_d    = sel_we;
          mem_re_d    = !sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_we ? sel_wdata : '0;
          mem_wstrb_d = sel_we ? sel_wstrb : '0;
          ptr_d       = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        rsp_resp_d  = bus.mem_resp_i;
        rsp_rdata_d = we_q ? '0 : bus.mem_rdata_i;
        rsp_valid_d = NUM_REQ'(1) << owner_q;
        state_d     = RESP;
      end
      RESP: begin
        // Only the owner's ready can retire the response.
        if (bus.rsp_ready_i[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_re_o    = mem_re_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wstrb_o = mem_wstrb_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_resp_o  = rsp_resp_q;
endmodule

// File: tb/tb_simple_if_rr_arbiter.sv
// Scoreboard bench for simple_if_rr_arbiter: directed requests push expected memory
// accesses and responses; negedge monitors pop and compare as the DUT presents them.
module tb_simple_if_rr_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int STRB_W  = DATA_W / 8;
  localparam logic [DATA_W-1:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  simple_if_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  simple_if_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus)
  );

  typedef struct {
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [DATA_W-1:0]  rdata;
    logic [1:0]         resp;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mdl_rdata = '0;
  logic [1:0]        mdl_resp  = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory backend: data/resp are only meaningful the cycle after a strobe.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.mem_rdata_i <= GARBAGE;
      bus.mem_resp_i  <= 2'b11;
    end else if (bus.mem_re_o) begin
      bus.mem_rdata_i <= mdl_rdata;
      bus.mem_resp_i  <= mdl_resp;
    end else if (bus.mem_we_o) begin
      bus.mem_rdata_i <= GARBAGE;
      bus.mem_resp_i  <= mdl_resp;
    end else begin
      bus.mem_rdata_i <= GARBAGE;
      bus.mem_resp_i  <= 2'b11;
    end
  end

  mem_exp_t me;
  rsp_exp_t re;
  always @(negedge clk) begin
    if (arst_n) begin
      if (bus.mem_we_o || bus.mem_re_o) begin
        check("mem_strobe_exclusive", bus.mem_we_o & bus.mem_re_o, 0);
        if (mem_q.size() == 0) begin
          check("mem_unexpected_strobe", {bus.mem_we_o, bus.mem_re_o}, 0);
        end else begin
          me = mem_q.pop_front();
          check("mem_we",    bus.mem_we_o,    me.we);
          check("mem_re",    bus.mem_re_o,    me.re);
          check("mem_addr",  bus.mem_addr_o,  me.addr);
          check("mem_wdata", bus.mem_wdata_o, me.wdata);
          check("mem_wstrb", bus.mem_wstrb_o, me.wstrb);
        end
      end
      if (|(bus.rsp_valid_o & bus.rsp_ready_i)) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid_o, 0);
        end else begin
          re = rsp_q.pop_front();
          check("rsp_valid", bus.rsp_valid_o, re.valid);
          check("rsp_rdata", bus.rsp_rdata_o, re.rdata);
          check("rsp_resp",  bus.rsp_resp_o,  re.resp);
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    mem_exp_t e;
    e.we = we; e.re = !we; e.addr = a; e.wdata = d; e.wstrb = s;
    mem_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [NUM_REQ-1:0] v, input logic [DATA_W-1:0] d,
                          input logic [1:0] r);
    rsp_exp_t e;
    e.valid = v; e.rdata = d; e.resp = r;
    rsp_q.push_back(e);
  endtask

  task automatic set_req(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    bus.req_we_i[p]                    = we;
    bus.req_addr_i[p*ADDR_W +: ADDR_W] = a;
    bus.req_wdata_i[p*DATA_W +: DATA_W] = d;
    bus.req_wstrb_i[p*STRB_W +: STRB_W] = s;
    bus.req_valid_i[p]                 = 1'b1;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Waits for the handshake of port p; returns 1 ns into the cycle after acceptance.
  task automatic wait_accept(input int p);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.req_ready_o[p] && bus.req_valid_i[p]) seen = 1'b1;
    end
    check($sformatf("accept_port%0d", p), seen, 1'b1);
    sync();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_strobes"}, {bus.mem_we_o, bus.mem_re_o}, 0);
    check({tag, "_mem_addr"},    bus.mem_addr_o, 0);
    check({tag, "_mem_wdata"},   bus.mem_wdata_o, 0);
    check({tag, "_mem_wstrb"},   bus.mem_wstrb_o, 0);
    check({tag, "_rsp_valid"},   bus.rsp_valid_o, 0);
    check({tag, "_rsp_rdata"},   bus.rsp_rdata_o, 0);
    check({tag, "_rsp_resp"},    bus.rsp_resp_o, 0);
    check({tag, "_req_ready"},   bus.req_ready_o, 0);
  endtask

  initial begin
    int n;
    bus.req_valid_i = '0;
    bus.req_we_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0;
    bus.rsp_ready_i = '1;

    // Reset state, then a quiet idle period.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    arst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {bus.mem_we_o, bus.mem_re_o, bus.req_ready_o, bus.rsp_valid_o}, 0);
    end

    // Port0 write: strobe at T+1, response at T+3.
    mdl_resp = 2'b00;
    push_mem(1'b1, 32'h10, 64'hDEAD_BEEF, 8'h0F);
    push_rsp(2'b01, 64'h0, 2'b00);
    sync();
    set_req(0, 1'b1, 32'h10, 64'hDEAD_BEEF, 8'h0F);
    wait_accept(0);
    bus.req_valid_i[0] = 1'b0;
    @(negedge clk);
    check("wr_we_at_T1", {bus.mem_we_o, bus.mem_re_o}, 2'b10);
    @(negedge clk);
    check("wr_quiet_at_T2", {bus.mem_we_o, bus.mem_re_o, bus.rsp_valid_o}, 0);
    @(negedge clk);
    check("wr_rsp_at_T3", bus.rsp_valid_o, 2'b01);

    // Port1 read: write data on the port must not leak onto the bus.
    mdl_rdata = 64'h1234;
    push_mem(1'b0, 32'h20, 64'h0, 8'h00);
    push_rsp(2'b10, 64'h1234, 2'b00);
    sync();
    set_req(1, 1'b0, 32'h20, 64'h9999, 8'hFF);
    wait_accept(1);
    bus.req_valid_i[1] = 1'b0;
    @(negedge clk);
    check("rd_re_at_T1", {bus.mem_we_o, bus.mem_re_o}, 2'b01);
    repeat (2) @(negedge clk);
    check("rd_rsp_at_T3", bus.rsp_valid_o, 2'b10);

    // Both ports valid continuously: grants alternate 0,1,0,1,...
    mdl_rdata = 64'hCAFE;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        push_mem(1'b1, 32'h100, 64'h0A0A, 8'hFF);
        push_rsp(2'b01, 64'h0, 2'b00);
      end else begin
        push_mem(1'b0, 32'h200, 64'h0, 8'h00);
        push_rsp(2'b10, 64'hCAFE, 2'b00);
      end
    end
    sync();
    set_req(0, 1'b1, 32'h100, 64'h0A0A, 8'hFF);
    set_req(1, 1'b0, 32'h200, 64'h7777, 8'h0F);
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (|(bus.req_ready_o & bus.req_valid_i)) n++;
    end
    check("rr_handshakes", n, 8);
    sync();
    bus.req_valid_i = '0;
    repeat (6) @(negedge clk);

    // Owner holds off the response; non-owner ready is ignored; pending request waits.
    bus.rsp_ready_i = 2'b10;
    mdl_rdata = 64'h5555;
    push_mem(1'b0, 32'h30, 64'h0, 8'h00);
    push_rsp(2'b01, 64'h5555, 2'b00);
    push_mem(1'b1, 32'h40, 64'hABCD, 8'h03);
    push_rsp(2'b10, 64'h0, 2'b00);
    sync();
    set_req(0, 1'b0, 32'h30, 64'h0, 8'h00);
    wait_accept(0);
    bus.req_valid_i[0] = 1'b0;
    set_req(1, 1'b1, 32'h40, 64'hABCD, 8'h03);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid_o, 2'b01);
      check("hold_rsp_rdata", bus.rsp_rdata_o, 64'h5555);
      check("hold_no_ready_no_strobe", {bus.req_ready_o, bus.mem_we_o, bus.mem_re_o}, 0);
    end
    sync();
    bus.rsp_ready_i = 2'b11;
    wait_accept(1);
    bus.req_valid_i[1] = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during CAPTURE: response dropped, pointer back to 0.
    mdl_rdata = 64'h4444;
    push_mem(1'b0, 32'h50, 64'h0, 8'h00);
    sync();
    set_req(0, 1'b0, 32'h50, 64'h0, 8'h00);
    wait_accept(0);
    bus.req_valid_i[0] = 1'b0;
    sync();
    arst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("after_reset_no_rsp", {bus.rsp_valid_o, bus.mem_we_o, bus.mem_re_o}, 0);
    end

    mdl_rdata = 64'h77;
    mdl_resp  = 2'b10;
    push_mem(1'b0, 32'h60, 64'h0, 8'h00);
    push_rsp(2'b01, 64'h77, 2'b10);
    sync();
    set_req(0, 1'b0, 32'h60, 64'h0, 8'h00);
    set_req(1, 1'b1, 32'h70, 64'h1, 8'h01);
    #1;
    check("ptr_restart_grant", bus.req_ready_o, 2'b01);
    wait_accept(0);
    bus.req_valid_i = '0;
    repeat (3) @(negedge clk);
    check("slverr_resp", bus.rsp_resp_o, 2'b10);

    for (int c = 0; c < 20 && (mem_q.size() != 0 || rsp_q.size() != 0); c++) @(negedge clk);
    check("mem_queue_drained", mem_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
